axis_video_crop: RTL and testbench
==================================

Name: axis_video_crop

Overview:
- Sits directly downstream of the camera capture/CDC stage; consumes its 16-bit RGB565 AXI4-Stream video (tuser = SOF, tlast = EOL).
- Outputs a rectangular sub-window of each frame as a compliant AXI4-Stream video stream, with tuser/tlast regenerated.
- Feeds the VDMA / stereo-processing path.
- Window size is run-time configurable and latched per frame; malformed input lines are detected and flagged.

Parameters:
- DATA_WIDTH, 16, pixel width in bits (tdata width).
- CNT_WIDTH, 12, width of column/row counters and crop config fields; maximum source dimension is 2^CNT_WIDTH-1.

Ports:
- axis_video_aclk  in  1  single clock for all logic.
- axis_video_aresetn  in  1  reset, synchronous, active-low.
- s_axis_video_tdata  in  DATA_WIDTH  input pixel.
- s_axis_video_tvalid  in  1  input valid.
- s_axis_video_tready  out  1  input ready.
- s_axis_video_tuser  in  1  input start of frame.
- s_axis_video_tlast  in  1  input end of line.
- m_axis_video_tdata  out  DATA_WIDTH  output pixel.
- m_axis_video_tvalid  out  1  output valid.
- m_axis_video_tready  in  1  output ready.
- m_axis_video_tuser  out  1  output SOF.
- m_axis_video_tlast  out  1  output EOL.
- crop_x, crop_y  in  CNT_WIDTH each  window origin (column, row).
- crop_w, crop_h  in  CNT_WIDTH each  window width and height in pixels/lines.
- frame_done  out  1  one-cycle pulse when the last window pixel enters the output buffer.
- line_trunc  out  1  sticky flag: input line ended inside an open output line.
- sof_resync  out  1  one-cycle pulse on an input SOF while a frame is in progress.

Behaviour:
- Clock and reset:
  - One clock: axis_video_aclk.
  - Reset axis_video_aresetn is synchronous, active-low.
  - While reset is low: state = WAIT_SOF, counters = 0, skid buffer empty.
  - Reset values: m_axis_video_tvalid/tuser/tlast = 0, tdata = 0, s_axis_video_tready = 0, frame_done = 0, sof_resync = 0, line_trunc = 0.
  - Reset asserted mid-frame discards all buffered and partial data; no partial packet is emitted after reset releases.
- Input acceptance:
  - A beat is accepted when s_tvalid & s_tready.
  - s_tready = ~reset & skid buffer not full; it is registered, with no combinational path from m_tready.
- Output buffer:
  - 2-entry skid buffer.
  - Latency from accepted input beat to m_tvalid is 1 cycle when the buffer is empty.
  - Full throughput: 1 pixel/clock with m_tready held high.
  - m_tdata/tuser/tlast stay stable while m_tvalid & ~m_tready.
- States:
  - WAIT_SOF: beats without tuser are dropped. A beat with tuser does the following: latch crop_x/y/w/h into shadow registers, set col = 0, row = 0, evaluate the beat as pixel (0,0), go to ACTIVE.
  - ACTIVE:
    - Each accepted beat is passed if x ≤ col ≤ x+w-1 and y ≤ row ≤ y+h-1, using shadow values with CNT_WIDTH+1-bit sums (no wrap). All other beats are dropped.
    - Output tuser = 1 only on pixel (x,y).
    - Output tlast = 1 when col == x+w-1.
    - On input tlast: col = 0, row = row+1; otherwise col = col+1. Both counters saturate at all-ones.
    - When the pixel at (x+w-1, y+h-1) is passed: pulse frame_done, go to DONE.
  - DONE: all beats are dropped. An input tuser beat behaves as in WAIT_SOF.
- Mid-frame SOF:
  - Input tuser accepted in ACTIVE with (col,row) ≠ (0,0) pulses sof_resync and restarts the frame: shadow config re-latched, beat treated as (0,0).
  - If an output line is open, force m_tlast on the last buffered pixel is NOT done; line_trunc is set instead.
- Truncated lines:
  - Input tlast on a passed beat with col < x+w-1 forces output tlast = 1 on that beat and sets line_trunc.
- Degenerate window:
  - crop_w == 0 or crop_h == 0: nothing is passed, no frame_done.
  - Window entirely beyond the source: nothing is passed.
- Config changes take effect only at the next SOF.
- line_trunc clears only on reset.

Optional Feature:
- Macro AXIS_VIDEO_CROP_STATS_EN.
- When defined, adds output ports frame_cnt[15:0] and drop_cnt[31:0]:
  - frame_cnt increments on each frame_done and wraps at 0xFFFF→0.
  - drop_cnt counts beats accepted but not passed, saturating at 0xFFFFFFFF.
  - Both reset to 0.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- 8x4 source frame, crop x=2,y=1,w=3,h=2, m_tready=1 → 6 output beats: tuser on pixel (2,1) only, tlast on (4,1) and (4,2), frame_done pulses once; s_tready stays 1.
- Same stimulus with m_tready toggling 1010… → identical output sequence, no loss or duplication; tdata/tuser/tlast stable while stalled.
- 5 junk beats before the first tuser, then 4x2 frame with crop 0,0,4,2 → junk dropped; output equals the full frame with tlast at col 3.
- Crop x=2,w=4 on a 4-pixel-wide source → output lines of 2 pixels, each with tlast; line_trunc = 1.
- New tuser injected at (3,1) of an 8x4 frame with crop 0,0,8,4 → sof_resync pulse; output restarts with tuser on the next beat; reset asserted mid-line afterwards → all outputs 0 next cycle.
- With AXIS_VIDEO_CROP_STATS_EN: three 8x4 frames cropped 2,1,3,2 → frame_cnt = 3, drop_cnt = 78.

Source files
------------

// File: rtl/axis_video_crop.sv
// AXI4-Stream video crop: passes a per-frame latched rectangular window, regenerates tuser/tlast.
// Optional statistics ports (frame_cnt, drop_cnt) are enabled by defining AXIS_VIDEO_CROP_STATS_EN.
module axis_video_crop #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                  axis_video_aclk,
  input  logic                  axis_video_aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_video_tdata,
  input  logic                  s_axis_video_tvalid,
  output logic                  s_axis_video_tready,
  input  logic                  s_axis_video_tuser,
  input  logic                  s_axis_video_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_video_tdata,
  output logic                  m_axis_video_tvalid,
  input  logic                  m_axis_video_tready,
  output logic                  m_axis_video_tuser,
  output logic                  m_axis_video_tlast,
  input  logic [CNT_WIDTH-1:0]  crop_x,
  input  logic [CNT_WIDTH-1:0]  crop_y,
  input  logic [CNT_WIDTH-1:0]  crop_w,
  input  logic [CNT_WIDTH-1:0]  crop_h,
  output logic                  frame_done,
  output logic                  line_trunc,
  output logic                  sof_resync
`ifdef AXIS_VIDEO_CROP_STATS_EN
  ,
  output logic [15:0]           frame_cnt,
  output logic [31:0]           drop_cnt
`endif
);

  localparam int CW1 = CNT_WIDTH + 1;
  localparam int EW  = DATA_WIDTH + 2;
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);
  localparam logic [CW1-1:0]       ONE1 = CW1'(1);

  // Handshake: a beat transfers on any rising edge where valid and ready are both high;
  // the source holds data stable while valid is high and ready is low.

  typedef enum logic [1:0] {WAIT_SOF, ACTIVE, DONE} state_t;
  state_t state, state_nxt;

  logic [CNT_WIDTH-1:0] sh_x, sh_y, sh_w, sh_h;
  logic [CNT_WIDTH-1:0] col, row;
  logic                 line_open;

  logic                 beat, sof_beat, live, pass;
  logic [CNT_WIDTH-1:0] ex, ey, ew, eh, ecol, erow;
  logic [CW1-1:0]       x_end, y_end;
  logic                 in_col, in_row, last_col, last_row;
  logic                 out_user, out_last, trunc_eol, win_done, resync;
  logic [CNT_WIDTH-1:0] col_nxt, row_nxt;

  logic [EW-1:0]        mem [2];
  logic                 rd_ptr, wr_ptr;
  logic [1:0]           cnt, cnt_nxt;
  logic                 push, pop;
  logic [EW-1:0]        head;

  assign beat     = s_axis_video_tvalid & s_axis_video_tready;
  assign sof_beat = beat & s_axis_video_tuser;

  // An SOF beat is judged against the fresh crop inputs at position (0,0).
  always_comb begin
    ex   = sof_beat ? crop_x : sh_x;
    ey   = sof_beat ? crop_y : sh_y;
    ew   = sof_beat ? crop_w : sh_w;
    eh   = sof_beat ? crop_h : sh_h;
    ecol = sof_beat ? '0 : col;
    erow = sof_beat ? '0 : row;
  end

  always_comb begin
    x_end     = {1'b0, ex} + {1'b0, ew};
    y_end     = {1'b0, ey} + {1'b0, eh};
    in_col    = (ew != '0) && (ecol >= ex) && ({1'b0, ecol} < x_end);
    in_row    = (eh != '0) && (erow >= ey) && ({1'b0, erow} < y_end);
    last_col  = ({1'b0, ecol} == (x_end - ONE1));
    last_row  = ({1'b0, erow} == (y_end - ONE1));
    live      = sof_beat || (state == ACTIVE);
    pass      = beat && live && in_col && in_row;
    out_user  = (ecol == ex) && (erow == ey);
    out_last  = last_col | s_axis_video_tlast;
    trunc_eol = pass & s_axis_video_tlast & ~last_col;
    win_done  = pass & last_col & last_row;
    resync    = sof_beat && (state == ACTIVE) && ((col != '0) || (row != '0));
  end

  // Position counters saturate so an oversize source cannot wrap back into the window.
  always_comb begin
    col_nxt = col;
    row_nxt = row;
    if (beat && live) begin
      if (s_axis_video_tlast) begin
        col_nxt = '0;
        row_nxt = (&erow) ? erow : erow + ONE;
      end else begin
        col_nxt = (&ecol) ? ecol : ecol + ONE;
        row_nxt = erow;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (sof_beat)
      state_nxt = win_done ? DONE : ACTIVE;
    else if ((state == ACTIVE) && win_done)
      state_nxt = DONE;
  end

  always_ff @(posedge axis_video_aclk) begin
    if (!axis_video_aresetn) begin
      state      <= WAIT_SOF;
      col        <= '0;
      row        <= '0;
      sh_x       <= '0;
      sh_y       <= '0;
      sh_w       <= '0;
      sh_h       <= '0;
      line_open  <= 1'b0;
      line_trunc <= 1'b0;
      frame_done <= 1'b0;
      sof_resync <= 1'b0;
    end else begin
      state      <= state_nxt;
      col        <= col_nxt;
      row        <= row_nxt;
      frame_done <= win_done;
      sof_resync <= resync;
      if (sof_beat) begin
        sh_x <= crop_x;
        sh_y <= crop_y;
        sh_w <= crop_w;
        sh_h <= crop_h;
      end
      if (pass)
        line_open <= ~out_last;
      else if (sof_beat)
        line_open <= 1'b0;
      // A restart with an open output line leaves that line unterminated downstream.
      if (trunc_eol || (resync && line_open))
        line_trunc <= 1'b1;
    end
  end

  // Two-entry output buffer; tready is registered from the next occupancy.
  assign push    = pass;
  assign pop     = m_axis_video_tvalid & m_axis_video_tready;
  assign cnt_nxt = cnt + {1'b0, push} - {1'b0, pop};
  assign head    = mem[rd_ptr];

  always_ff @(posedge axis_video_aclk) begin
    if (!axis_video_aresetn) begin
      cnt                 <= '0;
      rd_ptr              <= 1'b0;
      wr_ptr              <= 1'b0;
      s_axis_video_tready <= 1'b0;
    end else begin
      cnt                 <= cnt_nxt;
      s_axis_video_tready <= (cnt_nxt != 2'd2);
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge axis_video_aclk) begin
    if (push)
      mem[wr_ptr] <= {out_user, out_last, s_axis_video_tdata};
  end

  assign m_axis_video_tvalid = (cnt != 2'd0);
  assign m_axis_video_tuser  = m_axis_video_tvalid & head[EW-1];
  assign m_axis_video_tlast  = m_axis_video_tvalid & head[EW-2];
  assign m_axis_video_tdata  = m_axis_video_tvalid ? head[DATA_WIDTH-1:0] : '0;

`ifdef AXIS_VIDEO_CROP_STATS_EN
  always_ff @(posedge axis_video_aclk) begin
    if (!axis_video_aresetn) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (win_done)
        frame_cnt <= frame_cnt + 16'd1;
      if (beat && !pass && (drop_cnt != '1))
        drop_cnt <= drop_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_video_crop.sv
// Bench for axis_video_crop: table of crop cases plus hand sequences for junk, resync and mid-frame reset.
module tb_axis_video_crop;

  localparam int DW = 16;
  localparam int CW = 12;
  localparam int W  = DW + 2;

  logic          clk, rst_n;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid, s_tready, s_tuser, s_tlast;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tready, m_tuser, m_tlast;
  logic [CW-1:0] crop_x, crop_y, crop_w, crop_h;
  logic          frame_done, line_trunc, sof_resync;
`ifdef AXIS_VIDEO_CROP_STATS_EN
  logic [15:0]   frame_cnt;
  logic [31:0]   drop_cnt;
`endif

  axis_video_crop #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .axis_video_aclk     (clk),
    .axis_video_aresetn  (rst_n),
    .s_axis_video_tdata  (s_tdata),
    .s_axis_video_tvalid (s_tvalid),
    .s_axis_video_tready (s_tready),
    .s_axis_video_tuser  (s_tuser),
    .s_axis_video_tlast  (s_tlast),
    .m_axis_video_tdata  (m_tdata),
    .m_axis_video_tvalid (m_tvalid),
    .m_axis_video_tready (m_tready),
    .m_axis_video_tuser  (m_tuser),
    .m_axis_video_tlast  (m_tlast),
    .crop_x              (crop_x),
    .crop_y              (crop_y),
    .crop_w              (crop_w),
    .crop_h              (crop_h),
    .frame_done          (frame_done),
    .line_trunc          (line_trunc),
    .sof_resync          (sof_resync)
`ifdef AXIS_VIDEO_CROP_STATS_EN
    ,
    .frame_cnt           (frame_cnt),
    .drop_cnt            (drop_cnt)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state: entries are {tuser, tlast, tdata}
  logic [W-1:0] exp_q[$];
  int n_tests, n_fail;
  int n_out, n_done, n_resync, n_tready_low;
  int ready_mode;  // 0: always ready, 1: toggle, 2: held low
  logic         acc;
  logic         prev_stall;
  logic [W-1:0] prev_out;

  typedef struct {
    string name;
    int sw, sh, x, y, w, h, mode;
    int exp_beats, exp_done, exp_trunc;
  } case_t;
  case_t cases[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sample();
    logic [W-1:0] e;
    if (rst_n) begin
      if (prev_stall)
        check("stall_hold", 32'({m_tvalid, m_tuser, m_tlast, m_tdata}), 32'({1'b1, prev_out}));
      if (m_tvalid && m_tready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_beat: got 0x%0h expected no beat", {m_tuser, m_tlast, m_tdata});
        end else begin
          e = exp_q.pop_front();
          check("beat", 32'({m_tuser, m_tlast, m_tdata}), 32'(e));
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_out   = {m_tuser, m_tlast, m_tdata};
      if (frame_done) n_done++;
      if (sof_resync) n_resync++;
      if (!s_tready)  n_tready_low++;
    end else begin
      prev_stall = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    acc = s_tvalid && s_tready;
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = 1'b0;
    endcase
  endtask

  // Driver
  task automatic send_beat(input logic [DW-1:0] d, input logic u, input logic l);
    int guard;
    s_tdata  = d;
    s_tuser  = u;
    s_tlast  = l;
    s_tvalid = 1'b1;
    guard    = 0;
    do begin
      tick();
      guard++;
    end while (!acc && guard < 64);
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
    s_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int sw, input int sh, input int x, input int y,
                            input int w, input int h, input int max_beats);
    int n;
    logic [DW-1:0] d;
    logic u, l;
    crop_x = CW'(x);
    crop_y = CW'(y);
    crop_w = CW'(w);
    crop_h = CW'(h);
    n = 0;
    for (int r = 0; r < sh; r++) begin
      for (int c = 0; c < sw; c++) begin
        if (n >= max_beats) return;
        d = DW'($urandom_range(0, 65535));
        u = (r == 0) && (c == 0);
        l = (c == sw - 1);
        if (w > 0 && h > 0 && c >= x && c < x + w && r >= y && r < y + h)
          exp_q.push_back({(c == x) && (r == y), (c == x + w - 1) || l, d});
        send_beat(d, u, l);
        n++;
        // Scramble config mid-frame; only the SOF-time values may matter.
        if (n == 1) begin
          crop_x = CW'($urandom_range(0, 7));
          crop_y = CW'($urandom_range(0, 3));
          crop_w = CW'($urandom_range(0, 8));
          crop_h = CW'($urandom_range(0, 4));
        end
      end
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      tick();
      guard++;
    end
    repeat (4) tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    rst_n    = 1'b0;
    tick();
    tick();
    check("rst_outputs", 32'({m_tvalid, m_tuser, m_tlast, m_tdata, frame_done, sof_resync, line_trunc}), 32'd0);
    check("rst_tready", 32'(s_tready), 32'd0);
    rst_n = 1'b1;
    exp_q.delete();
    tick();
    check("tready_after_rst", 32'(s_tready), 32'd1);
    n_out = 0; n_done = 0; n_resync = 0; n_tready_low = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0;
    n_out = 0; n_done = 0; n_resync = 0; n_tready_low = 0;
    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tuser = 1'b0; s_tlast = 1'b0;
    m_tready = 1'b1; ready_mode = 0; acc = 1'b0; prev_stall = 1'b0; prev_out = '0;
    crop_x = '0; crop_y = '0; crop_w = '0; crop_h = '0;

    //                name          sw sh  x  y  w  h mode beats done trunc
    cases[0] = '{"basic",          8, 4, 2, 1, 3, 2, 0,   6,  1,  0};
    cases[1] = '{"stall_toggle",   8, 4, 2, 1, 3, 2, 1,   6,  1,  0};
    cases[2] = '{"full_4x2",       4, 2, 0, 0, 4, 2, 0,   8,  1,  0};
    cases[3] = '{"trunc_right",    4, 2, 2, 0, 4, 2, 0,   4,  0,  1};
    cases[4] = '{"zero_width",     8, 4, 0, 0, 0, 2, 0,   0,  0,  0};
    cases[5] = '{"zero_height",    8, 4, 0, 0, 3, 0, 0,   0,  0,  0};
    cases[6] = '{"beyond_source",  8, 4,10, 0, 2, 2, 0,   0,  0,  0};
    cases[7] = '{"corner_1x1",     8, 4, 7, 3, 1, 1, 1,   1,  1,  0};
    cases[8] = '{"full_8x4",       8, 4, 0, 0, 8, 4, 1,  32,  1,  0};

    for (int i = 0; i < 9; i++) begin
      ready_mode = 0;
      do_reset();
      ready_mode = cases[i].mode;
      send_frame(cases[i].sw, cases[i].sh, cases[i].x, cases[i].y, cases[i].w, cases[i].h, 1000);
      drain();
      check({cases[i].name, "_beats"}, 32'(n_out), 32'(cases[i].exp_beats));
      check({cases[i].name, "_done"}, 32'(n_done), 32'(cases[i].exp_done));
      check({cases[i].name, "_trunc"}, 32'(line_trunc), 32'(cases[i].exp_trunc));
      check({cases[i].name, "_resync"}, 32'(n_resync), 32'd0);
      if (cases[i].mode == 0)
        check({cases[i].name, "_tready_low"}, 32'(n_tready_low), 32'd0);
    end

    // Junk before the first SOF is dropped
    ready_mode = 0;
    do_reset();
    for (int j = 0; j < 5; j++)
      send_beat(DW'($urandom_range(0, 65535)), 1'b0, 1'($urandom_range(0, 1)));
    send_frame(4, 2, 0, 0, 4, 2, 1000);
    drain();
    check("junk_beats", 32'(n_out), 32'd8);
    check("junk_done", 32'(n_done), 32'd1);

    // New SOF at (3,1) restarts the frame with an open output line
    do_reset();
    send_frame(8, 4, 0, 0, 8, 4, 11);
    send_frame(8, 4, 0, 0, 8, 4, 1000);
    drain();
    check("resync_pulse", 32'(n_resync), 32'd1);
    check("resync_trunc", 32'(line_trunc), 32'd1);
    check("resync_beats", 32'(n_out), 32'd43);
    check("resync_done", 32'(n_done), 32'd1);

    // Reset mid-line with data held in the output buffer
    ready_mode = 2;
    m_tready = 1'b0;
    send_frame(8, 4, 0, 0, 8, 4, 2);
    check("midrst_buffered", 32'(m_tvalid), 32'd1);
    rst_n = 1'b0;
    tick();
    check("midrst_outputs", 32'({m_tvalid, m_tuser, m_tlast, m_tdata, frame_done, sof_resync, line_trunc}), 32'd0);
    check("midrst_tready", 32'(s_tready), 32'd0);
    ready_mode = 0;
    rst_n = 1'b1;
    exp_q.delete();
    n_out = 0;
    repeat (10) tick();
    check("midrst_no_emit", 32'(n_out), 32'd0);

`ifdef AXIS_VIDEO_CROP_STATS_EN
    do_reset();
    for (int f = 0; f < 3; f++)
      send_frame(8, 4, 2, 1, 3, 2, 1000);
    drain();
    check("stats_frame_cnt", 32'(frame_cnt), 32'd3);
    check("stats_drop_cnt", drop_cnt, 32'd78);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
